// File: rtl/uartrx_fifo_if.sv
// Bus bundle between uartrx_fifo and its environment: the uartrx byte handshake
// on one side and the CPU-facing read/status port on the other.
interface uartrx_fifo_if #(
  parameter int Depth         = 16,
  parameter int CountBitWidth = $clog2(Depth) + 1
);
  logic [7:0]               uartrx_data;
  logic                     uartrx_data_ready;
  logic                     uartrx_go;
  logic                     rd_en;
  logic [31:0]              rd_data;
  logic [CountBitWidth-1:0] count;
  logic                     empty;
  logic                     full;
  logic                     overflow;
  logic                     clr_overflow;

  modport master (
    output uartrx_data, uartrx_data_ready, rd_en, clr_overflow,
    input  uartrx_go, rd_data, count, empty, full, overflow
  );

  modport slave (
    input  uartrx_data, uartrx_data_ready, rd_en, clr_overflow,
    output uartrx_go, rd_data, count, empty, full, overflow
  );
endinterface

// File: rtl/uartrx_fifo.sv
// Receive byte FIFO that autonomously acknowledges uartrx and presents the head
// byte in UART-in register format (zero-extended byte, or all ones when empty).
module uartrx_fifo #(
  parameter int Depth         = 16,
  parameter int CountBitWidth = $clog2(Depth) + 1
) (
  input logic           clk,
  input logic           rst_n,
  uartrx_fifo_if.slave  bus
);
  localparam int PtrBitWidth = $clog2(Depth);

  typedef enum logic {
    RECV = 1'b0,
    ACK  = 1'b1
  } state_t;

  state_t                   state_q, state_d;
  logic [PtrBitWidth-1:0]   wp_q, wp_d;
  logic [PtrBitWidth-1:0]   rp_q, rp_d;
  logic [CountBitWidth-1:0] count_q, count_d;
  logic                     overflow_q, overflow_d;
  logic [7:0]               mem_q [Depth];

  logic empty;
  logic full;
  logic pop;
  logic push;
  logic drop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CountBitWidth'(Depth));

  always_comb begin
    state_d    = state_q;
    push       = 1'b0;
    drop       = 1'b0;
    pop        = bus.rd_en && !empty;
    // data_ready is only looked at in RECV, so a held byte is taken exactly once
    case (state_q)
      RECV: begin
        if (bus.uartrx_data_ready) begin
          if (!full || pop) push = 1'b1;
          else              drop = 1'b1;
          state_d = ACK;
        end
      end
      ACK: begin
        if (!bus.uartrx_data_ready) state_d = RECV;
      end
      default: state_d = RECV;
    endcase

    wp_d = push ? wp_q + 1'b1 : wp_q;
    rp_d = pop  ? rp_q + 1'b1 : rp_q;

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // a drop in the same cycle as a clear must leave the flag set
    if (drop)                  overflow_d = 1'b1;
    else if (bus.clr_overflow) overflow_d = 1'b0;
    else                       overflow_d = overflow_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RECV;
      wp_q       <= '0;
      rp_q       <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q] <= bus.uartrx_data;
  end

  assign bus.uartrx_go = (state_q == RECV);
  assign bus.rd_data   = empty ? 32'hffff_ffff : {24'h0, mem_q[rp_q]};
  assign bus.count     = count_q;
  assign bus.empty     = empty;
  assign bus.full      = full;
  assign bus.overflow  = overflow_q;
endmodule
